// File: rtl/push_btn_debouncer.sv
// push_btn_debouncer
//   Conditions a raw board push button for SYS_CLK-domain control logic.
//   The pin is synchronised, bounce and glitches are rejected, and the block
//   produces a clean pressed level plus one-cycle press, release and
//   long-press pulses and a wrapping 8-bit press counter.
// Ports
//   SYS_CLK           system clock, all logic on posedge
//   RST               synchronous active-high reset
//   BTN_IN            raw asynchronous button pin
//   BTN_LEVEL         debounced level, 1 = pressed
//   PRESS_PULSE       1-cycle pulse on an accepted press
//   RELEASE_PULSE     1-cycle pulse on an accepted release
//   LONG_PRESS_PULSE  1-cycle pulse, at most once per press
//   PRESS_COUNT       accepted presses, wraps 255 -> 0
module push_btn_debouncer #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 200_000_000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       BTN_IN,
  output logic       BTN_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PRESS_PULSE,
  output logic [7:0] PRESS_COUNT
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]    cnt;
  logic [HCNT_W-1:0]   hcnt;
  logic                btn_s;
  logic [HCNT_W-1:0]   hcnt_inc_c;

  // Synchroniser chain; reset loads the released pin level so no false press.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], BTN_IN};
    end
  end

  // Normalised pressed indication: 1 = pressed regardless of pin polarity.
  assign btn_s = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

  // Saturating hold count. The long-press threshold is compared on this
  // updated value so the pulse lands LONG_PRESS_CYCLES-1 cycles after
  // PRESS_PULSE; saturation above the threshold keeps it to once per press.
  assign hcnt_inc_c = (hcnt == HCNT_MAX) ? hcnt : hcnt + HCNT_W'(1);

  // Debounce FSM with registered outputs.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state            <= IDLE;
      cnt              <= '0;
      hcnt             <= '0;
      BTN_LEVEL        <= 1'b0;
      PRESS_PULSE      <= 1'b0;
      RELEASE_PULSE    <= 1'b0;
      LONG_PRESS_PULSE <= 1'b0;
      PRESS_COUNT      <= 8'd0;
    end else begin
      PRESS_PULSE      <= 1'b0;
      RELEASE_PULSE    <= 1'b0;
      LONG_PRESS_PULSE <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            PRESS_PULSE <= 1'b1;
            BTN_LEVEL   <= 1'b1;
            PRESS_COUNT <= PRESS_COUNT + 8'd1;
            hcnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          hcnt <= hcnt_inc_c;
          if (hcnt_inc_c == HCNT_LAST) begin
            LONG_PRESS_PULSE <= 1'b1;
          end
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          // Hold time keeps accruing so a bouncing release still counts as held.
          hcnt <= hcnt_inc_c;
          if (hcnt_inc_c == HCNT_LAST) begin
            LONG_PRESS_PULSE <= 1'b1;
          end
          if (btn_s) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            RELEASE_PULSE <= 1'b1;
            BTN_LEVEL     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
